table5x4_writer: RTL
====================

// Module: table5x4_writer
// PURPOSE
//  Write side of the 5x4 x 32-bit lookup table. Takes single-word write requests over a
//  valid/ready handshake, addressed by one-hot row and binary column, and holds all 20 words
//  in registers. Also runs a timed clear sweep. Drives the flattened table into the selector
//  inputs in_RxC.
// PARAMETERS
//  DATA_W     32     width of one table entry
//  RESET_VAL  32'h0  value loaded into every entry on reset and by the clear sweep
// PORTS
//  clk        in   1          sole clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  wr_valid   in   1          write request valid
//  wr_ready   out  1          write request accepted when wr_valid & wr_ready at clk edge
//  wr_row     in   5          one-hot row select (bit r = row r)
//  wr_col     in   2          binary column select 0..3
//  wr_data    in   DATA_W     write data
//  clr_req    in   1          level; starts clear sweep when sampled high in IDLE
//  busy       out  1          high while clear sweep runs
//  clr_done   out  1          one-cycle pulse after the last sweep write
//  wr_err     out  1          one-cycle pulse: accepted request had wr_row not one-hot
//  tbl_flat   out  20*DATA_W  entry (r,c) at bits [(r*4+c)*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset: all entries = RESET_VAL, state IDLE, busy=0, clr_done=0, wr_err=0. Reset mid-sweep
//   abandons the sweep.
//  States: IDLE, CLEAR.
//   IDLE->CLEAR when clr_req=1. Load idx=0.
//   CLEAR: write RESET_VAL to entry idx (idx = r*4+c), idx++ each cycle.
//   CLEAR->IDLE after idx=19 is written. 20 cycles in CLEAR. clr_done pulses on the first IDLE cycle.
//  wr_ready = (state==IDLE) & ~clr_req. This is combinational, so clr_req beats a same-cycle write.
//   A write held on wr_valid waits and is accepted after the sweep.
//  Accepted write with exactly one wr_row bit set: entry (row,col) <= wr_data. Visible on tbl_flat
//   the cycle after the accepting edge (1-cycle latency). tbl_flat is purely registered.
//  Accepted write with wr_row zero or multi-hot: no entry changes. wr_err pulses the next cycle.
//   The handshake still completes, so the requester never deadlocks.
//  busy = (state==CLEAR). clr_req held high after the sweep starts a new sweep immediately after
//   clr_done.
//  idx counter is 5 bits, saturates at 19 and never wraps past the table.
// CONFIGURATION
//  TABLE5X4_WRITER_BYTE_EN_EN defined:
//   - Extra input wr_be [DATA_W/8] adds byte enables.
//   - Only bytes with wr_be[i]=1 are updated on a valid write.
//   - wr_be=0 on a one-hot write is legal. Nothing changes and no error is flagged.
//   - The clear sweep ignores wr_be and writes full words.
//  Not defined: port wr_be absent; every accepted write updates the full word.
// TESTING
//  1 Reset: rst_n=0 mid-sweep -> every tbl_flat word = RESET_VAL, busy=0, wr_ready=1 after release.
//  2 Write row=5'b00100 col=2 data=32'hCAFE0001 -> tbl_flat word 10 = CAFE0001 one cycle later.
//    No other word changes.
//  3 Write row=5'b00110 (multi-hot) or 5'b00000 -> handshake completes, wr_err pulses once,
//    table unchanged.
//  4 Fill all 20 words, then pulse clr_req -> busy high exactly 20 cycles, clr_done one pulse,
//    all words = RESET_VAL.
//  5 clr_req and wr_valid in the same IDLE cycle -> wr_ready=0, sweep runs. The held write is
//    accepted after clr_done and its value survives.
//  6 BYTE_EN build: word (4,3)=32'h11223344, write 32'hAABBCCDD with wr_be=4'b0101
//    -> 32'h11BB33DD.

Source files
------------

// File: rtl/table5x4_writer.sv
// table5x4_writer
//   Write side of a 5x4 lookup table of DATA_W-bit words. It accepts single-word
//   writes over a valid/ready handshake and can run a timed clear sweep. All 20
//   entries are held in registers and driven out flattened on tbl_flat.
//
//   Optional build macro: TABLE5X4_WRITER_BYTE_EN_EN
//     This macro adds the wr_be byte-enable input. The clear sweep always writes
//     full words.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wr_valid  write request valid
//   wr_ready  write accepted when wr_valid & wr_ready at a clk edge
//   wr_row    one-hot row select (bit r = row r)
//   wr_col    binary column select, 0..3
//   wr_data   write data
//   wr_be     byte enables (only with TABLE5X4_WRITER_BYTE_EN_EN)
//   clr_req   level request; starts a clear sweep when sampled high in IDLE
//   busy      high while the clear sweep runs
//   clr_done  one-cycle pulse on the first IDLE cycle after a sweep
//   wr_err    one-cycle pulse after an accepted write whose wr_row is not one-hot
//   tbl_flat  entry (r,c) at bits [(r*4+c)*DATA_W +: DATA_W]
module table5x4_writer #(
  parameter int unsigned         DATA_W    = 32,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [4:0]           wr_row,
  input  logic [1:0]           wr_col,
  input  logic [DATA_W-1:0]    wr_data,
`ifdef TABLE5X4_WRITER_BYTE_EN_EN
  input  logic [DATA_W/8-1:0]  wr_be,
`endif
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  output logic                 wr_err,
  output logic [20*DATA_W-1:0] tbl_flat
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [4:0]        idx;
  logic [DATA_W-1:0] tbl [20];

  logic              row_ok;
  logic [2:0]        row_idx;
  logic [4:0]        wr_idx;

  // A request for a clear sweep has priority over a write in the same cycle.
  assign wr_ready = (state == IDLE) && !clr_req;
  assign busy     = (state == CLEAR);

  // A row value is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  always_comb begin
    row_ok  = (wr_row != '0) && ((wr_row & (wr_row - 5'd1)) == '0);
    row_idx = '0;
    for (int unsigned r = 0; r < 5; r++) begin
      if (wr_row[r]) row_idx = 3'(r);
    end
    // This value equals r*4+c. It is at most 19 whenever row_ok is high.
    wr_idx = {row_idx, wr_col};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
      for (int unsigned i = 0; i < 20; i++) tbl[i] <= RESET_VAL;
    end else begin
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
          end else if (wr_valid) begin
            if (row_ok) begin
`ifdef TABLE5X4_WRITER_BYTE_EN_EN
              for (int unsigned b = 0; b < DATA_W/8; b++) begin
                if (wr_be[b]) tbl[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
              end
`else
              tbl[wr_idx] <= wr_data;
`endif
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          tbl[idx] <= RESET_VAL;
          // The index saturates at the last entry, so it never addresses past the table.
          if (idx == 5'd19) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 20; g++) begin : g_flat
    assign tbl_flat[g*DATA_W +: DATA_W] = tbl[g];
  end

endmodule
